// File: rtl/uart_receiver.sv
// UART receive stage: 16x oversampled, 8 data bits LSB first, optional parity, one stop bit.
// Emits each byte with a one-cycle valid strobe plus sticky parity/framing flags.
module uart_receiver #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUDRATE    = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pen,
  input  logic       peven,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       valid,
  output logic       perr,
  output logic       ferr,
  output logic       busy,
  output logic [2:0] state_dbg
);

  localparam int OS_RAW    = (CLK_FREQ_HZ + BAUDRATE * 8) / (BAUDRATE * 16);
  localparam int OS_CYCLES = (OS_RAW < 1) ? 1 : OS_RAW;
  localparam int OS_W      = (OS_CYCLES > 1) ? $clog2(OS_CYCLES) : 1;
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OS_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic            sync1_q, rxs_q;
  logic [OS_W-1:0] os_cnt_q, os_cnt_d;
  logic [3:0]      tick_q, tick_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      data_q, data_d;
  logic            pen_q, pen_d;
  logic            peven_q, peven_d;
  logic            par_err_q, par_err_d;
  logic [7:0]      dout_q, dout_d;
  logic            valid_q, valid_d;
  logic            perr_q, perr_d;
  logic            ferr_q, ferr_d;
  logic            ostick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= rx;
      rxs_q   <= sync1_q;
    end
  end

  // Oversample prescaler sits at zero while idle so the first tick lands a fixed delay after detection.
  assign ostick = (state_q != S_IDLE) && (os_cnt_q == OS_LAST);

  always_comb begin
    os_cnt_d = os_cnt_q + OS_W'(1);
    if (state_q == S_IDLE || ostick) os_cnt_d = '0;
  end

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    data_d    = data_q;
    pen_d     = pen_q;
    peven_d   = peven_q;
    par_err_d = par_err_q;
    dout_d    = dout_q;
    valid_d   = 1'b0;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          state_d   = S_START;
          tick_d    = 4'd0;
          bit_d     = 3'd0;
          pen_d     = pen;
          peven_d   = peven;
          par_err_d = 1'b0;
        end
      end
      S_START: begin
        if (ostick) begin
          if (tick_q == 4'd7) begin
            tick_d  = 4'd0;
            bit_d   = 3'd0;
            state_d = rxs_q ? S_IDLE : S_DATA;
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (ostick) begin
          tick_d = tick_q + 4'd1;
          if (tick_q == 4'd15) begin
            data_d[bit_q] = rxs_q;
            if (bit_q == 3'd7) state_d = pen_q ? S_PARITY : S_STOP;
            else               bit_d   = bit_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (ostick) begin
          tick_d = tick_q + 4'd1;
          if (tick_q == 4'd15) begin
            par_err_d = rxs_q ^ (peven_q ? (^data_q) : ~(^data_q));
            state_d   = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (ostick) begin
          tick_d = tick_q + 4'd1;
          if (tick_q == 4'd15) begin
            valid_d = 1'b1;
            dout_d  = data_q;
            perr_d  = pen_q & par_err_q;
            ferr_d  = ~rxs_q;
            // A low stop bit parks in BREAK so a held-low line cannot start a new frame.
            state_d = rxs_q ? S_IDLE : S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      os_cnt_q  <= '0;
      tick_q    <= 4'd0;
      bit_q     <= 3'd0;
      data_q    <= 8'h00;
      pen_q     <= 1'b0;
      peven_q   <= 1'b0;
      par_err_q <= 1'b0;
      dout_q    <= 8'h00;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      os_cnt_q  <= os_cnt_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      pen_q     <= pen_d;
      peven_q   <= peven_d;
      par_err_q <= par_err_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  assign dout      = dout_q;
  assign valid     = valid_q;
  assign perr      = perr_q;
  assign ferr      = ferr_q;
  assign busy      = (state_q != S_IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 32 MHz / 1 Mbaud (2 clocks per tick, 32 clocks per bit).
module tb_uart_receiver;

  localparam int BIT_CLKS = 32;

  logic       clk;
  logic       rst;
  logic       pen;
  logic       peven;
  logic       rx;
  logic [7:0] dout;
  logic       valid;
  logic       perr;
  logic       ferr;
  logic       busy;
  logic [2:0] state_dbg;

  int n_tests;
  int n_fail;

  // Entries are {ferr, perr, dout}.
  logic [9:0] exp_q[$];
  logic [9:0] obs_q[$];

  uart_receiver #(
    .CLK_FREQ_HZ(32000000),
    .BAUDRATE   (1000000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pen      (pen),
    .peven    (peven),
    .rx       (rx),
    .dout     (dout),
    .valid    (valid),
    .perr     (perr),
    .ferr     (ferr),
    .busy     (busy),
    .state_dbg(state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every high cycle of valid is captured, so a stretched strobe shows up as an extra entry.
  always @(negedge clk) begin
    if (valid === 1'b1) obs_q.push_back({ferr, perr, dout});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(posedge clk);
    #1;
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * BIT_CLKS) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic with_par, input logic par_bit,
                            input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (with_par) send_bit(par_bit);
    send_bit(stop_bit);
  endtask

  // Scoreboard drain: bounded wait, then count and content comparison.
  task automatic drain(input string tag);
    int budget;
    budget = 2000;
    while (obs_q.size() < exp_q.size() && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #1;
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) check(tag, obs_q.pop_front(), exp_q.pop_front());
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b0;
    rx      = 1'b1;
    pen     = 1'b0;
    peven   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_dout", dout, 32'h00);
    check("reset_flags", {valid, perr, ferr, busy}, 32'h0);
    check("reset_state", state_dbg, 32'h0);
    rst = 1'b1;
    idle_bits(2);

    // 0x55, no parity
    exp_q.push_back({1'b0, 1'b0, 8'h55});
    send_frame(8'h55, 1'b0, 1'b0, 1'b1);
    idle_bits(1);
    drain("frame_55");
    check("busy_after_55", busy, 32'h0);

    // 0xA7 has five ones: even parity bit 1, odd parity bit 0
    pen = 1'b1; peven = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 8'hA7});
    send_frame(8'hA7, 1'b1, 1'b1, 1'b1);
    idle_bits(1);
    drain("even_par_ok");
    exp_q.push_back({1'b0, 1'b1, 8'hA7});
    send_frame(8'hA7, 1'b1, 1'b0, 1'b1);
    idle_bits(1);
    drain("even_par_bad");
    check("perr_held", perr, 32'h1);
    peven = 1'b0;
    exp_q.push_back({1'b0, 1'b0, 8'hA7});
    send_frame(8'hA7, 1'b1, 1'b0, 1'b1);
    idle_bits(1);
    drain("odd_par_ok");
    pen = 1'b0;

    // Back-to-back frames with no idle gap
    exp_q.push_back({1'b0, 1'b0, 8'h00});
    exp_q.push_back({1'b0, 1'b0, 8'hFF});
    send_frame(8'h00, 1'b0, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
    idle_bits(1);
    drain("back_to_back");

    // Short low glitch: 12 clocks
    rx = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("glitch_busy_high", busy, 32'h1);
    repeat (6) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("glitch_busy_low", busy, 32'h0);
    idle_bits(1);
    drain("glitch_no_valid");

    // Line held low for 20 bit times
    exp_q.push_back({1'b1, 1'b0, 8'h00});
    rx = 1'b0;
    repeat (20 * BIT_CLKS) @(posedge clk);
    #1;
    check("break_busy_held", busy, 32'h1);
    idle_bits(1);
    check("break_busy_released", busy, 32'h0);
    drain("break_frame");
    exp_q.push_back({1'b0, 1'b0, 8'h3C});
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    idle_bits(1);
    drain("after_break_3c");
    check("ferr_cleared", ferr, 32'h0);

    // Reset in the middle of D4 of 0x81
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    rx = 1'b0;
    repeat (BIT_CLKS / 2) @(posedge clk);
    #1;
    check("pre_abort_busy", busy, 32'h1);
    rst = 1'b0;
    #1;
    check("abort_dout", dout, 32'h00);
    check("abort_flags", {valid, perr, ferr, busy}, 32'h0);
    rx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    idle_bits(2);
    drain("abort_no_valid");
    exp_q.push_back({1'b0, 1'b0, 8'h81});
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    idle_bits(1);
    drain("after_abort_81");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
